// File: rtl/req_issuer.sv
// req_issuer: buffers producer requests in a pending counter and issues each
// one as a single-cycle req pulse, checking that gnt answers on the next
// cycle and leaving one idle cycle before the next req.
//
// state | meaning
// IDLE  | nothing in flight, waiting for pending > 0
// REQ   | req high for exactly one cycle, wait counter cleared
// WAIT  | waiting for gnt, at most TIMEOUT cycles
// GAP   | req low for one cycle so gnt can fall
module req_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  output logic                       push_ready,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       req,
  input  logic                       gnt,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout_err,
  output logic                       late_gnt,
  output logic                       proto_err,
  output logic [CNT_W-1:0]           gnt_count,
  output logic [CNT_W-1:0]           err_count
);

  localparam int PW = $clog2(DEPTH+1);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] FULL      = PW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT-1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_GAP
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [WW-1:0]   wait_cnt;
  logic            grant;
  logic            expire;
  logic            accept;
  logic            leave;

  // push_ready looks only at the registered count, so a completion in the
  // same cycle does not open a slot until the following cycle.
  assign push_ready = (pending < FULL);
  assign accept     = push && push_ready;
  assign leave      = grant || expire;
  assign req        = (state == S_REQ);
  assign busy       = (state != S_IDLE);

  // Next-state decode and WAIT exit classification.
  always_comb begin
    state_n = state;
    grant   = 1'b0;
    expire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending != '0) state_n = S_REQ;
      end
      S_REQ: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (gnt) begin
          state_n = S_GAP;
          grant   = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_n = S_GAP;
          expire  = 1'b1;
        end
      end
      S_GAP: begin
        state_n = (pending != '0) ? S_REQ : S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State register and WAIT cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == S_REQ) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT && !leave) begin
        wait_cnt <= wait_cnt + WW'(1);
      end
    end
  end

  // Pending count: +1 on accepted push, -1 when a transaction leaves WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else if (accept && !leave) begin
      pending <= pending + PW'(1);
    end else if (!accept && leave) begin
      pending <= pending - PW'(1);
    end
  end

  // Completion pulse, sticky error flags and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      timeout_err <= 1'b0;
      late_gnt    <= 1'b0;
      proto_err   <= 1'b0;
      gnt_count   <= '0;
      err_count   <= '0;
    end else begin
      done <= grant;
      if (expire) timeout_err <= 1'b1;
      if (grant && wait_cnt != '0) late_gnt <= 1'b1;
      if (gnt && state != S_WAIT) proto_err <= 1'b1;
      if (grant && gnt_count != '1) gnt_count <= gnt_count + CNT_W'(1);
      if (expire && err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
